procb_buf: RTL and testbench



---
 rtl/procb_buf.sv | 132 +++++++++++++
 tb/tb_procb_buf.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/procb_buf.sv
// procb_buf: per-thread ring buffer of {addr, bytes, finish_ctx} records feeding process_bytes.
// Optional macro PROCB_BUF_CHECK_EN enables protocol checking and the sticky err output.
module procb_buf #(
    parameter int N_THREADS = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = 8,
    localparam int N_THREADS_MSB = $clog2(N_THREADS) - 1,
    localparam int DEPTH_MSB     = $clog2(DEPTH) - 1,
    localparam int D_WIDTH       = ADDR_W + CNT_W + 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_THREADS_MSB:0] wr_thread_num,
    input  logic                   wr_en,
    input  logic [D_WIDTH-1:0]     din,
    output logic                   wr_full,
    input  logic [N_THREADS_MSB:0] rd_thread_num,
    input  logic                   lookup_en,
    input  logic                   rd_en,
    input  logic                   rd_rst,
    output logic                   lookup_empty,
    output logic [D_WIDTH-1:0]     dout,
    output logic                   err
);
    localparam int PW = DEPTH_MSB + 2;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);

    logic [D_WIDTH-1:0] r_mem [N_THREADS*DEPTH];
    logic [PW-1:0]      r_wrPtr [N_THREADS];
    logic [PW-1:0]      r_rdPtr [N_THREADS];
    logic [1:0]         r_la;

    logic [PW-1:0] w_wrOcc;
    logic [PW-1:0] w_lookPos;
    logic          w_wrOk;
    logic          w_lookOk;
    logic          w_rdOk;
    logic [1:0]    w_laNext;

    always_comb begin
        w_wrOcc      = r_wrPtr[wr_thread_num] - r_rdPtr[wr_thread_num];
        wr_full      = (w_wrOcc == PTR_DEPTH);
        w_lookPos    = r_rdPtr[rd_thread_num] + PW'(r_la);
        lookup_empty = (w_lookPos == r_wrPtr[rd_thread_num]);
        dout         = r_mem[{rd_thread_num, w_lookPos[DEPTH_MSB:0]}];
    end

    // Accepted actions; without checks the caller is trusted for lookups and commits.
    always_comb begin
        w_wrOk = wr_en & ~wr_full & ~rd_rst;
`ifdef PROCB_BUF_CHECK_EN
        w_rdOk   = rd_en & (r_la != 2'd0);
        w_lookOk = lookup_en & ~lookup_empty & ~(~w_rdOk & (r_la == 2'd2));
`else
        w_rdOk   = rd_en;
        w_lookOk = lookup_en;
`endif
        case ({w_lookOk, w_rdOk})
            2'b10:   w_laNext = r_la + 2'd1;
            2'b11:   w_laNext = r_la;
            2'b01:   w_laNext = r_la - 2'd1;
            default: w_laNext = 2'd0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_wrOk) begin
            r_mem[{wr_thread_num, r_wrPtr[wr_thread_num][DEPTH_MSB:0]}] <= din;
        end
    end

    // An idle read cycle drops la to zero so an unconsumed lookup is presented again.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_THREADS; i++) begin
                r_wrPtr[i] <= '0;
                r_rdPtr[i] <= '0;
            end
            r_la <= 2'd0;
        end else if (rd_rst) begin
            for (int i = 0; i < N_THREADS; i++) begin
                r_wrPtr[i] <= '0;
                r_rdPtr[i] <= '0;
            end
            r_la <= 2'd0;
        end else begin
            if (w_wrOk) begin
                r_wrPtr[wr_thread_num] <= r_wrPtr[wr_thread_num] + PTR_ONE;
            end
            if (w_rdOk) begin
                r_rdPtr[rd_thread_num] <= r_rdPtr[rd_thread_num] + PTR_ONE;
            end
            r_la <= w_laNext;
        end
    end

`ifdef PROCB_BUF_CHECK_EN
    logic w_errNow;
    logic r_err;

    assign w_errNow = ~rd_rst & ((wr_en & wr_full)
                               | (lookup_en & lookup_empty)
                               | (rd_en & (r_la == 2'd0))
                               | (lookup_en & ~w_rdOk & (r_la == 2'd2)));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (rd_rst) begin
            r_err <= 1'b0;
        end else if (w_errNow) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

`ifdef SIMULATION
    always @(posedge CLK) begin
        if (!RST && w_errNow) begin
            $display("procb_buf: protocol error at %0t (wr_en=%b full=%b lookup_en=%b empty=%b rd_en=%b la=%0d)",
                     $time, wr_en, wr_full, lookup_en, lookup_empty, rd_en, r_la);
        end
    end
`endif
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_procb_buf.sv
// Directed testbench for procb_buf: expectations are queued by the stimulus and
// checked by an independent monitor on the falling clock edge.
module tb_procb_buf;
    localparam int DW = 25;

`ifdef PROCB_BUF_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic          CLK;
    logic          RST;
    logic [2:0]    wr_thread_num;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          wr_full;
    logic [2:0]    rd_thread_num;
    logic          lookup_en;
    logic          rd_en;
    logic          rd_rst;
    logic          lookup_empty;
    logic [DW-1:0] dout;
    logic          err;

    procb_buf #(.N_THREADS(8), .DEPTH(4), .ADDR_W(16), .CNT_W(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .wr_thread_num(wr_thread_num),
        .wr_en        (wr_en),
        .din          (din),
        .wr_full      (wr_full),
        .rd_thread_num(rd_thread_num),
        .lookup_en    (lookup_en),
        .rd_en        (rd_en),
        .rd_rst       (rd_rst),
        .lookup_empty (lookup_empty),
        .dout         (dout),
        .err          (err)
    );

    typedef struct {
        string         name;
        logic          chkData;
        logic [DW-1:0] data;
        logic          empty;
        logic          full;
        logic          errv;
    } exp_t;

    exp_t          expQ[$];
    exp_t          cur;
    logic          chkReq;
    logic          stickyErr;
    int            testsRun;
    int            testsFailed;
    logic [DW-1:0] drainRecs [4];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] rec(input int a, input int b, input logic f);
        return {a[15:0], b[7:0], f};
    endfunction

    task automatic compareVal(input string nm, input string field, input logic [DW-1:0] act, input logic [DW-1:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, req);
        end
    endtask

    // Monitor: pops one expectation whenever the stimulus requests a check.
    always @(negedge CLK) begin
        if (chkReq) begin
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL monitor: check requested with no expectation queued");
            end else begin
                cur = expQ.pop_front();
                compareVal(cur.name, "lookup_empty", DW'(lookup_empty), DW'(cur.empty));
                compareVal(cur.name, "wr_full", DW'(wr_full), DW'(cur.full));
                compareVal(cur.name, "err", DW'(err), DW'(cur.errv));
                if (cur.chkData) begin
                    compareVal(cur.name, "dout", dout, cur.data);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] t_wt, input logic t_we, input logic [DW-1:0] t_d,
                                 input logic [2:0] t_rt, input logic t_le, input logic t_re);
        wr_thread_num = t_wt;
        wr_en         = t_we;
        din           = t_d;
        rd_thread_num = t_rt;
        lookup_en     = t_le;
        rd_en         = t_re;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string nm, input logic cd, input logic [DW-1:0] d,
                               input logic emp, input logic full, input logic e);
        exp_t x;
        x.name    = nm;
        x.chkData = cd;
        x.data    = d;
        x.empty   = emp;
        x.full    = full;
        x.errv    = e;
        expQ.push_back(x);
        chkReq = 1'b1;
        @(negedge CLK);
        #1;
        chkReq = 1'b0;
    endtask

    // Looks up and commits n records of thread th, writing an unused thread so wr_full stays low.
    task automatic drain(input logic [2:0] th, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(3'd7, 1'b0, '0, th, 1'b1, (i > 0));
            checkOutput($sformatf("drain_t%0d_%0d", th, i), 1'b1, drainRecs[i], 1'b0, 1'b0, stickyErr);
            step();
        end
        applyStimulus(3'd7, 1'b0, '0, th, 1'b0, 1'b1);
        checkOutput($sformatf("drain_t%0d_last", th), 1'b0, '0, 1'b1, 1'b0, stickyErr);
        step();
        applyStimulus(3'd7, 1'b0, '0, th, 1'b0, 1'b0);
        checkOutput($sformatf("drain_t%0d_empty", th), 1'b0, '0, 1'b1, 1'b0, stickyErr);
        step();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] r, a, b, c;
        testsRun    = 0;
        testsFailed = 0;
        chkReq      = 1'b0;
        stickyErr   = 1'b0;
        RST         = 1'b1;
        rd_rst      = 1'b0;
        applyStimulus(3'd0, 1'b0, '0, 3'd0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("reset", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        RST = 1'b0;
        step();

        // Single record, visible only after the write edge.
        r = rec(5, 10, 1'b0);
        applyStimulus(3'd2, 1'b1, r, 3'd2, 1'b0, 1'b0);
        checkOutput("t1_nobypass", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step();
        applyStimulus(3'd2, 1'b0, '0, 3'd2, 1'b0, 1'b0);
        checkOutput("t1_visible", 1'b1, r, 1'b0, 1'b0, 1'b0);
        step();

        // Pipelined lookup/commit of three records.
        a = rec(17, 1, 1'b0);
        b = rec(18, 2, 1'b0);
        c = rec(19, 3, 1'b1);
        applyStimulus(3'd1, 1'b1, a, 3'd1, 1'b0, 1'b0); step();
        applyStimulus(3'd1, 1'b1, b, 3'd1, 1'b0, 1'b0); step();
        applyStimulus(3'd1, 1'b1, c, 3'd1, 1'b0, 1'b0); step();
        applyStimulus(3'd1, 1'b0, '0, 3'd1, 1'b1, 1'b0);
        checkOutput("t2_lookA", 1'b1, a, 1'b0, 1'b0, 1'b0); step();
        applyStimulus(3'd1, 1'b0, '0, 3'd1, 1'b1, 1'b1);
        checkOutput("t2_lookB", 1'b1, b, 1'b0, 1'b0, 1'b0); step();
        applyStimulus(3'd1, 1'b0, '0, 3'd1, 1'b1, 1'b1);
        checkOutput("t2_lookC", 1'b1, c, 1'b0, 1'b0, 1'b0); step();
        applyStimulus(3'd1, 1'b0, '0, 3'd1, 1'b0, 1'b1);
        checkOutput("t2_lastrd", 1'b0, '0, 1'b1, 1'b0, 1'b0); step();
        applyStimulus(3'd1, 1'b0, '0, 3'd1, 1'b0, 1'b0);
        checkOutput("t2_drained", 1'b0, '0, 1'b1, 1'b0, 1'b0); step();

        // Full rollback on thread 0.
        a = rec(32, 4, 1'b0);
        b = rec(33, 5, 1'b1);
        applyStimulus(3'd0, 1'b1, a, 3'd0, 1'b0, 1'b0); step();
        applyStimulus(3'd0, 1'b1, b, 3'd0, 1'b0, 1'b0); step();
        applyStimulus(3'd0, 1'b0, '0, 3'd0, 1'b1, 1'b0);
        checkOutput("t3_lookA", 1'b1, a, 1'b0, 1'b0, 1'b0); step();
        applyStimulus(3'd0, 1'b0, '0, 3'd0, 1'b0, 1'b0);
        checkOutput("t3_ahead", 1'b1, b, 1'b0, 1'b0, 1'b0); step();
        checkOutput("t3_rollback", 1'b1, a, 1'b0, 1'b0, 1'b0); step();
        applyStimulus(3'd0, 1'b0, '0, 3'd0, 1'b1, 1'b0);
        checkOutput("t3_relookA", 1'b1, a, 1'b0, 1'b0, 1'b0); step();
        applyStimulus(3'd0, 1'b0, '0, 3'd0, 1'b0, 1'b1);
        checkOutput("t3_commitA", 1'b1, b, 1'b0, 1'b0, 1'b0); step();
        applyStimulus(3'd0, 1'b0, '0, 3'd0, 1'b0, 1'b0);
        checkOutput("t3_afterCommit", 1'b1, b, 1'b0, 1'b0, 1'b0); step();

        // Partial rollback on thread 4, then fill it to show occupancy 1 remained.
        a = rec(64, 6, 1'b0);
        b = rec(65, 7, 1'b1);
        applyStimulus(3'd4, 1'b1, a, 3'd4, 1'b0, 1'b0); step();
        applyStimulus(3'd4, 1'b1, b, 3'd4, 1'b0, 1'b0); step();
        applyStimulus(3'd4, 1'b0, '0, 3'd4, 1'b1, 1'b0);
        checkOutput("t4_lookA", 1'b1, a, 1'b0, 1'b0, 1'b0); step();
        applyStimulus(3'd4, 1'b0, '0, 3'd4, 1'b1, 1'b1);
        checkOutput("t4_lookB", 1'b1, b, 1'b0, 1'b0, 1'b0); step();
        applyStimulus(3'd4, 1'b0, '0, 3'd4, 1'b0, 1'b0);
        checkOutput("t4_aheadEmpty", 1'b0, '0, 1'b1, 1'b0, 1'b0); step();
        checkOutput("t4_partial", 1'b1, b, 1'b0, 1'b0, 1'b0); step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'd4, 1'b1, rec(66 + i, i, 1'b0), 3'd4, 1'b0, 1'b0);
            if (i == 2) checkOutput("t4_occ3", 1'b1, b, 1'b0, 1'b0, 1'b0);
            step();
        end
        applyStimulus(3'd4, 1'b0, '0, 3'd4, 1'b0, 1'b0);
        checkOutput("t4_full", 1'b1, b, 1'b0, 1'b1, 1'b0); step();

        // Fill thread 3, overflow, drain, refill and wrap the pointers.
        for (int i = 0; i < 4; i++) begin
            drainRecs[i] = rec(100 + i, 20 + i, i[0]);
            applyStimulus(3'd3, 1'b1, drainRecs[i], 3'd3, 1'b0, 1'b0); step();
        end
        applyStimulus(3'd3, 1'b0, '0, 3'd3, 1'b0, 1'b0);
        checkOutput("t5_full", 1'b1, drainRecs[0], 1'b0, 1'b1, 1'b0); step();
        applyStimulus(3'd3, 1'b1, rec(200, 0, 1'b0), 3'd3, 1'b0, 1'b0);
        checkOutput("t5_ovfPre", 1'b1, drainRecs[0], 1'b0, 1'b1, 1'b0); step();
        stickyErr = CHK;
        applyStimulus(3'd3, 1'b0, '0, 3'd3, 1'b0, 1'b0);
        checkOutput("t5_ovfErr", 1'b1, drainRecs[0], 1'b0, 1'b1, stickyErr); step();
        drain(3'd3, 4);
        for (int i = 0; i < 4; i++) begin
            drainRecs[i] = rec(300 + i, 40 + i, ~i[0]);
            applyStimulus(3'd3, 1'b1, drainRecs[i], 3'd3, 1'b0, 1'b0); step();
        end
        applyStimulus(3'd3, 1'b0, '0, 3'd3, 1'b0, 1'b0);
        checkOutput("t5_refull", 1'b1, drainRecs[0], 1'b0, 1'b1, stickyErr); step();
        drain(3'd3, 4);
        r = rec(400, 9, 1'b1);
        applyStimulus(3'd3, 1'b1, r, 3'd3, 1'b0, 1'b0); step();
        applyStimulus(3'd3, 1'b0, '0, 3'd3, 1'b0, 1'b0);
        checkOutput("t5_wrapped", 1'b1, r, 1'b0, 1'b0, stickyErr); step();

        // Synchronous clear beats a simultaneous write.
        r = rec(500, 11, 1'b0);
        applyStimulus(3'd5, 1'b1, r, 3'd5, 1'b0, 1'b0); step();
        applyStimulus(3'd5, 1'b0, '0, 3'd5, 1'b0, 1'b0);
        checkOutput("t6_pre", 1'b1, r, 1'b0, 1'b0, stickyErr); step();
        rd_rst = 1'b1;
        applyStimulus(3'd5, 1'b1, rec(501, 0, 1'b0), 3'd5, 1'b0, 1'b0); step();
        rd_rst    = 1'b0;
        stickyErr = 1'b0;
        applyStimulus(3'd4, 1'b0, '0, 3'd5, 1'b0, 1'b0);
        checkOutput("t6_thread5", 1'b0, '0, 1'b1, 1'b0, 1'b0); step();
        applyStimulus(3'd4, 1'b0, '0, 3'd0, 1'b0, 1'b0);
        checkOutput("t6_thread0", 1'b0, '0, 1'b1, 1'b0, 1'b0); step();
        applyStimulus(3'd5, 1'b0, '0, 3'd4, 1'b0, 1'b0);
        checkOutput("t6_thread4", 1'b0, '0, 1'b1, 1'b0, 1'b0); step();

        // Lookup on an empty thread flags err; async reset clears it between edges.
        r = rec(600, 1, 1'b1);
        applyStimulus(3'd6, 1'b1, r, 3'd6, 1'b0, 1'b0); step();
        applyStimulus(3'd6, 1'b0, '0, 3'd7, 1'b1, 1'b0); step();
        stickyErr = CHK;
        applyStimulus(3'd6, 1'b0, '0, 3'd7, 1'b0, 1'b0); step();
        applyStimulus(3'd6, 1'b0, '0, 3'd6, 1'b0, 1'b0);
        checkOutput("t7_emptyLookErr", 1'b1, r, 1'b0, 1'b0, stickyErr);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        checkOutput("t7_asyncRst", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        RST = 1'b0;
        step();

        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard: %0d expectations left unchecked, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
